deserializer: RTL



---
 rtl/deserializer_pkg.sv | 13 +
 rtl/deserializer_out_buf.sv | 77 +++++++
 rtl/deserializer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/deserializer_pkg.sv
// Shared types and constants for the serial-to-parallel receive stage.
package deser_pkg;

    // Receive framing state: waiting for a start bit, or collecting a frame.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

    // Number of completed words that can wait for the consumer.
    localparam int DESER_BUF_DEPTH = 2;

endpackage

// File: rtl/deserializer_out_buf.sv
// Small synchronous FIFO holding completed words until the consumer takes them.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module deser_out_buf
    import deser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = DESER_BUF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         valid_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset clears contents so the head reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel receive stage: rebuilds MSB-first frames into words,
// buffers them for a valid/ready consumer and keeps link error statistics.
module deserializer
    import deser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  serial_in,
    input  logic                  enable,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] parallel_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  abort_pulse,
    output logic                  drop_pulse,
    output logic [CNT_WIDTH-1:0]  abort_count,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic [CNT_WIDTH-1:0]  stray_count
);

    localparam int BC_W      = $clog2(DATA_WIDTH) + 1;
    localparam int BUF_CNT_W = $clog2(DESER_BUF_DEPTH + 1);
    localparam logic [BC_W-1:0]      LAST_BIT = BC_W'(DATA_WIDTH - 1);
    localparam logic [BUF_CNT_W-1:0] BUF_FULL = BUF_CNT_W'(DESER_BUF_DEPTH);

    deser_state_t          state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [BC_W-1:0]       bit_cnt_q;
    logic                  abort_pulse_q;
    logic                  drop_pulse_q;
    logic [CNT_WIDTH-1:0]  abort_cnt_q;
    logic [CNT_WIDTH-1:0]  drop_cnt_q;
    logic [CNT_WIDTH-1:0]  stray_cnt_q;

    logic                  frame_done;
    logic                  buf_pop;
    logic                  buf_push;
    logic                  buf_room;
    logic                  buf_full;
    logic                  buf_valid;
    logic                  drop;
    logic [BUF_CNT_W-1:0]  buf_count;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A start bit always wins over completion, so only a non-start beat can finish a frame.
    assign shift_d    = {shift_q[DATA_WIDTH-2:0], serial_in};
    assign frame_done = enable && !start && (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
    assign buf_pop    = buf_valid && ready;
    assign buf_room   = (buf_count != BUF_FULL) || buf_pop;
    assign buf_push   = frame_done && buf_room;
    assign drop       = frame_done && buf_full && !buf_pop;

    // Framing FSM, shift register, bit counter, error pulses and saturating counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            abort_pulse_q <= 1'b0;
            drop_pulse_q  <= 1'b0;
            abort_cnt_q   <= '0;
            drop_cnt_q    <= '0;
            stray_cnt_q   <= '0;
        end else begin
            abort_pulse_q <= 1'b0;
            drop_pulse_q  <= drop;
            if (drop) begin
                drop_cnt_q <= sat_inc(drop_cnt_q);
            end
            if (enable) begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= BC_W'(1);
                            state_q   <= SHIFT;
                        end else begin
                            stray_cnt_q <= sat_inc(stray_cnt_q);
                        end
                    end
                    SHIFT: begin
                        shift_q <= shift_d;
                        if (start) begin
                            abort_pulse_q <= 1'b1;
                            abort_cnt_q   <= sat_inc(abort_cnt_q);
                            bit_cnt_q     <= BC_W'(1);
                        end else if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    deser_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DESER_BUF_DEPTH)
    ) u_out_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .data_i  (shift_d),
        .data_o  (parallel_out),
        .valid_o (buf_valid),
        .full_o  (buf_full),
        .count_o (buf_count)
    );

    assign valid       = buf_valid;
    assign abort_pulse = abort_pulse_q;
    assign drop_pulse  = drop_pulse_q;
    assign abort_count = abort_cnt_q;
    assign drop_count  = drop_cnt_q;
    assign stray_count = stray_cnt_q;

endmodule
